dpram_stream_reader: RTL and testbench

DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

---
 rtl/dpram_stream_reader.sv | 180 ++++++++++++++++++
 tb/tb_dpram_stream_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_reader.sv
// Streams a contiguous block of DPRAM words out through a small FIFO.
// Reads are credit-limited so every in-flight word always has a FIFO slot.
module dpram_stream_reader #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddress,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rdata,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   raddress_q, raddress_d;
  logic                cap_q, cap_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    captured_q, captured_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic                fifo_last_q [FIFO_DEPTH];

  logic [1:0]          inflight;
  logic [CNT_W:0]      occupancy;
  logic                credit_ok;
  logic                push;
  logic                pop;
  logic                push_last;

  // A read is in flight while in the raddress register (rd_en_q) and
  // while in the DPRAM output register (cap_q).
  assign inflight  = {1'b0, rd_en_q} + {1'b0, cap_q};
  assign occupancy = {1'b0, fifo_count_q} + {{(CNT_W - 1){1'b0}}, inflight};
  assign credit_ok = (occupancy < DEPTH_C);
  assign push      = cap_q;
  assign pop       = m_valid & m_ready;
  assign push_last = (captured_q == (length_q - 1'b1));

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign raddress = raddress_q;
  assign m_valid  = (fifo_count_q != '0);
  assign m_data   = fifo_data_q[rd_ptr_q];
  assign m_last   = m_valid & fifo_last_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_en_d      = 1'b0;
    raddress_d   = raddress_q;
    cap_d        = rd_en_q;
    length_d     = length_q;
    issued_d     = issued_q;
    captured_d   = captured_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            // The first read goes out on the accepting edge itself.
            busy_d     = 1'b1;
            length_d   = length;
            rd_en_d    = 1'b1;
            raddress_d = base_addr;
            issued_d   = LEN_W'(1);
            captured_d = '0;
            state_d    = (length == LEN_W'(1)) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (credit_ok && (issued_q < length_q)) begin
          rd_en_d    = 1'b1;
          raddress_d = raddress_q + 1'b1;
          issued_d   = issued_q + 1'b1;
          if ((issued_q + 1'b1) == length_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && m_last) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      captured_d = captured_d + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      raddress_q   <= '0;
      cap_q        <= 1'b0;
      length_q     <= '0;
      issued_q     <= '0;
      captured_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      raddress_q   <= raddress_d;
      cap_q        <= cap_d;
      length_q     <= length_d;
      issued_q     <= issued_d;
      captured_q   <= captured_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rdata;
        fifo_last_q[wr_ptr_q] <= push_last;
      end
    end
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Randomised and directed checks of dpram_stream_reader against a
// word-list model built from base address and length.
module tb_dpram_stream_reader;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, rd_en, m_valid, m_last;
  logic [AW-1:0] raddress;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dpram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .raddress(raddress),
    .rd_en(rd_en), .rdata(rdata), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DPRAM preloaded with mem[i] = i + 0x100, registered read.
  always @(posedge clk) rdata <= {{(DW - AW){1'b0}}, raddress} + 32'h100;

  logic [AW-1:0] addr_q[$];
  int            rd_cyc_q[$];
  logic [DW:0]   xfer_q[$];
  int            xfer_cyc_q[$];
  int            done_cyc_q[$];
  int            busy_cnt, valid_cnt, stall_err, credit_err;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (rd_en) begin
      addr_q.push_back(raddress);
      rd_cyc_q.push_back(cyc);
    end
    if (rd_cyc_q.size() - xfer_q.size() > D) credit_err++;
    if (m_valid && m_ready) begin
      xfer_q.push_back({m_last, m_data});
      xfer_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
    if (busy) busy_cnt++;
    if (m_valid) valid_cnt++;
    if (prev_stall && !(m_valid && m_data === prev_data && m_last === prev_last)) stall_err++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete(); rd_cyc_q.delete(); xfer_q.delete();
    xfer_cyc_q.delete(); done_cyc_q.delete();
    busy_cnt = 0; valid_cnt = 0; stall_err = 0; credit_err = 0;
    prev_stall = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_rd_en"}, longint'(rd_en), 0);
    chk({tag, "_raddress"}, longint'(raddress), 0);
    chk({tag, "_m_valid"}, longint'(m_valid), 0);
    chk({tag, "_m_last"}, longint'(m_last), 0);
    chk({tag, "_m_data"}, longint'(m_data), 0);
  endtask

  // mode 0: m_ready high; 1: random 50%; 2: low for 10 cycles then high.
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] len,
                          input int mode, input bit poke_start);
    int s, n, budget;
    bit timeout;
    logic [AW-1:0] ea;
    logic [DW:0]   ew;
    clear_mon();
    n = int'(len);
    budget = 100 + 8 * n;
    @(posedge clk) #1;
    start = 1'b1; base_addr = b; length = len; s = cyc;
    m_ready = (mode == 2) ? 1'b0 : (mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
    timeout = 1;
    for (int i = 1; i < budget; i++) begin
      @(posedge clk) #1;
      if (poke_start && i == 3) begin
        start = 1'b1; base_addr = AW'($urandom); length = 5;
      end else begin
        start = 1'b0;
      end
      if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) m_ready = (i >= 10);
      else m_ready = 1'b1;
      if (mode == 2 && i == 10) chk("stall_issue_count", longint'(rd_cyc_q.size()), 4);
      if (done_cyc_q.size() > 0) begin
        timeout = 0;
        break;
      end
    end
    start = 1'b0;
    m_ready = 1'b1;
    chk("timeout", longint'(timeout), 0);
    chk("xfer_count", longint'(xfer_q.size()), longint'(n));
    chk("rd_count", longint'(addr_q.size()), longint'(n));
    for (int k = 0; k < n; k++) begin
      ea = b + AW'(k);
      ew = {(k == n - 1), ({{(DW - AW){1'b0}}, ea} + 32'h100)};
      if (k < addr_q.size()) chk($sformatf("addr[%0d]", k), longint'(addr_q[k]), longint'(ea));
      if (k < xfer_q.size()) chk($sformatf("word[%0d]", k), longint'(xfer_q[k]), longint'(ew));
    end
    chk("done_count", longint'(done_cyc_q.size()), 1);
    if (done_cyc_q.size() > 0 && xfer_cyc_q.size() == n) begin
      chk("done_after_last", longint'(done_cyc_q[0]), longint'(xfer_cyc_q[n - 1] + 1));
      chk("busy_cycles", longint'(busy_cnt), longint'(done_cyc_q[0] - s - 1));
    end
    chk("stall_stable", longint'(stall_err), 0);
    chk("credit", longint'(credit_err), 0);
    if (mode == 0 && rd_cyc_q.size() > 0 && xfer_cyc_q.size() == n) begin
      chk("first_rd_cycle", longint'(rd_cyc_q[0] - s), 1);
      for (int k = 0; k < n; k++)
        chk($sformatf("xfer_cycle[%0d]", k), longint'(xfer_cyc_q[k] - s), longint'(3 + k));
    end
    $display("xfer base=%06h len=%0d mode=%0d words=%0d", b, n, mode, xfer_q.size());
  endtask

  initial begin
    int s;
    clear_mon();
    #2;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_xfer(21'h000010, 22'd8, 0, 0);
    run_xfer(21'h1FFFFE, 22'd4, 0, 0);
    run_xfer(21'h000200, 22'd16, 1, 1);
    run_xfer(21'h000300, 22'd8, 2, 0);

    // zero-length request
    clear_mon();
    @(posedge clk) #1;
    start = 1'b1; base_addr = 21'h55; length = '0; s = cyc;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("zero_done_count", longint'(done_cyc_q.size()), 1);
    if (done_cyc_q.size() > 0) chk("zero_done_cycle", longint'(done_cyc_q[0] - s), 1);
    chk("zero_rd_count", longint'(rd_cyc_q.size()), 0);
    chk("zero_valid", longint'(valid_cnt), 0);
    chk("zero_busy", longint'(busy_cnt), 0);
    $display("xfer base=000055 len=0 done_pulses=%0d", done_cyc_q.size());

    for (int it = 0; it < 6; it++) begin
      logic [AW-1:0] rb;
      rb = (it % 2 == 0) ? AW'($urandom) : (21'h1FFFFF - AW'($urandom_range(0, 8)));
      run_xfer(rb, 22'($urandom_range(1, 20)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a transfer
    clear_mon();
    @(posedge clk) #1;
    start = 1'b1; base_addr = 21'h40; length = 22'd8; m_ready = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (xfer_q.size() >= 3) break;
      @(posedge clk) #1;
    end
    chk("rst_third_word", longint'(xfer_q.size()), 3);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", longint'(done_cyc_q.size()), 0);
    chk("midrst_no_more_words", longint'(xfer_q.size()), 3);
    $display("reset after %0d words, done_pulses=%0d", xfer_q.size(), done_cyc_q.size());
    reset_n = 1'b1;
    run_xfer(21'h000000, 22'd2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
